// File: rtl/gpmc_bus_ctrl.sv
// gpmc_bus_ctrl: turns asynchronous multiplexed GPMC CS1 accesses into single-cycle register-bus requests.
// Latency: BUS_WE asserts SYNC_STAGES+2 cycles after the WEIN pin rises; read data reaches the pins 1 cycle after BUS_ACK.
// Backpressure: WAIT_ACK stalls until BUS_ACK. Optional ack timeout is enabled by `define GPMC_ACK_TIMEOUT_EN.
module gpmc_bus_ctrl #(
  parameter int          ADDR_W      = 16,
  parameter int          SYNC_STAGES = 2,
  parameter int          ACK_TIMEOUT = 255,
  parameter logic [15:0] ERR_DATA    = 16'hDEAD
) (
  input  logic              CLK_100M,
  input  logic              RST,
  input  logic [15:0]       GPMC_AD_IN,
  output logic [15:0]       GPMC_AD_OUT,
  output logic              GPMC_AD_OE,
  input  logic              GPMC_ADVN,
  input  logic              GPMC_CSN1,
  input  logic              GPMC_WEIN,
  input  logic              GPMC_OEN,
  input  logic              GPMC_BE0N,
  output logic [ADDR_W-1:0] BUS_ADDR,
  output logic [15:0]       BUS_WDATA,
  output logic [1:0]        BUS_BE,
  output logic              BUS_WE,
  output logic              BUS_RE,
  input  logic [15:0]       BUS_RDATA,
  input  logic              BUS_ACK,
  output logic              BUSY,
  output logic              ERR
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("gpmc_bus_ctrl: SYNC_STAGES must be 2..4");
  end
  if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 65535) begin : g_bad_tmo
    $error("gpmc_bus_ctrl: ACK_TIMEOUT must be 1..65535");
  end

  typedef enum logic [2:0] {IDLE, ADDR, WR_REQ, RD_REQ, WAIT_ACK, DRIVE, DONE} state_t;

  // strobe bit positions inside each synchronizer stage
  localparam int B_ADV = 0;
  localparam int B_CS  = 1;
  localparam int B_WE  = 2;
  localparam int B_OE  = 3;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0][3:0] stb_sync;
  logic [3:0]  stb;
  logic        adv_prev, we_prev, oe_prev;
  logic        adv_rise_q, we_rise_q, oe_fall_q;
  logic [15:0] ad_q;
  logic        be0n_q;
  logic        is_read;
  logic        stale_ack;
  logic        ack_ok;
  logic        tmo;
  logic        err_set;
  logic        csn_hi;

  assign stb    = stb_sync[SYNC_STAGES-1];
  assign csn_hi = stb[B_CS];
  // an ack owed to an aborted access must not complete the next one
  assign ack_ok = BUS_ACK && !stale_ack;

  // strobe synchronizers, AD/BE capture and registered edge pulses off the last sync stage
  always_ff @(posedge CLK_100M) begin
    if (RST) begin
      stb_sync   <= '1;
      adv_prev   <= 1'b1;
      we_prev    <= 1'b1;
      oe_prev    <= 1'b1;
      adv_rise_q <= 1'b0;
      we_rise_q  <= 1'b0;
      oe_fall_q  <= 1'b0;
      ad_q       <= '0;
      be0n_q     <= 1'b1;
    end else begin
      stb_sync   <= {stb_sync[SYNC_STAGES-2:0], {GPMC_OEN, GPMC_WEIN, GPMC_CSN1, GPMC_ADVN}};
      adv_prev   <= stb[B_ADV];
      we_prev    <= stb[B_WE];
      oe_prev    <= stb[B_OE];
      adv_rise_q <= stb[B_ADV] & ~adv_prev;
      we_rise_q  <= stb[B_WE] & ~we_prev;
      oe_fall_q  <= ~stb[B_OE] & oe_prev;
      ad_q       <= GPMC_AD_IN;
      be0n_q     <= GPMC_BE0N;
    end
  end

`ifdef GPMC_ACK_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  // count cycles spent in WAIT_ACK; restarts from zero on every entry
  always_ff @(posedge CLK_100M) begin
    if (RST || state != WAIT_ACK) tmo_cnt <= '0;
    else                          tmo_cnt <= tmo_cnt + 16'd1;
  end

  assign tmo = (state == WAIT_ACK) && (tmo_cnt == 16'(ACK_TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif

  // state register
  always_ff @(posedge CLK_100M) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state logic; CS deassertion mid-access aborts straight back to IDLE
  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    case (state)
      IDLE:     if (!stb[B_CS] && !stb[B_ADV]) state_nxt = ADDR;
      ADDR: begin
        if (csn_hi) state_nxt = IDLE;
        else if (!stb[B_WE] && !stb[B_OE]) begin
          err_set   = 1'b1;
          state_nxt = DONE;
        end
        else if (we_rise_q) state_nxt = WR_REQ;
        else if (oe_fall_q) state_nxt = RD_REQ;
      end
      WR_REQ,
      RD_REQ:   state_nxt = csn_hi ? IDLE : WAIT_ACK;
      WAIT_ACK: begin
        if (csn_hi) state_nxt = IDLE;
        else if (ack_ok) state_nxt = is_read ? DRIVE : DONE;
        else if (tmo) begin
          err_set   = 1'b1;
          state_nxt = is_read ? DRIVE : DONE;
        end
      end
      DRIVE: begin
        if (csn_hi) state_nxt = IDLE;
        else if (stb[B_OE]) state_nxt = DONE;
      end
      DONE:     if (csn_hi) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // outputs: request pulses are suppressed once CS has gone away, AD drive follows OEN level
  always_comb begin
    BUSY       = (state != IDLE);
    BUS_WE     = (state == WR_REQ) && !csn_hi;
    BUS_RE     = (state == RD_REQ) && !csn_hi;
    GPMC_AD_OE = (state == DRIVE) && !stb[B_OE] && !csn_hi;
  end

  // datapath: address/data latches, read data, sticky error and stale-ack tracking
  always_ff @(posedge CLK_100M) begin
    if (RST) begin
      BUS_ADDR    <= '0;
      BUS_WDATA   <= '0;
      BUS_BE      <= '0;
      GPMC_AD_OUT <= '0;
      ERR         <= 1'b0;
      is_read     <= 1'b0;
      stale_ack   <= 1'b0;
    end else begin
      if (state == ADDR && adv_rise_q) begin
        BUS_ADDR <= ADDR_W'(ad_q);
        BUS_BE   <= {1'b1, ~be0n_q};
      end
      if (state == ADDR && state_nxt == WR_REQ) begin
        BUS_WDATA <= ad_q;
        is_read   <= 1'b0;
      end
      if (state == ADDR && state_nxt == RD_REQ) is_read <= 1'b1;
      if (state == WAIT_ACK && state_nxt == DRIVE) GPMC_AD_OUT <= ack_ok ? BUS_RDATA : ERR_DATA;
      if (err_set) ERR <= 1'b1;
      if (BUS_ACK) stale_ack <= 1'b0;
      else if (state == WAIT_ACK && csn_hi) stale_ack <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gpmc_bus_ctrl.sv
// tb_gpmc_bus_ctrl: directed vector bench for gpmc_bus_ctrl.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: the bench plays the register-bus slave and chooses the ack delay per vector.
module tb_gpmc_bus_ctrl;

  logic        CLK_100M = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] GPMC_AD_IN = '0;
  logic [15:0] GPMC_AD_OUT;
  logic        GPMC_AD_OE;
  logic        GPMC_ADVN = 1'b1;
  logic        GPMC_CSN1 = 1'b1;
  logic        GPMC_WEIN = 1'b1;
  logic        GPMC_OEN = 1'b1;
  logic        GPMC_BE0N = 1'b1;
  logic [15:0] BUS_ADDR;
  logic [15:0] BUS_WDATA;
  logic [1:0]  BUS_BE;
  logic        BUS_WE;
  logic        BUS_RE;
  logic [15:0] BUS_RDATA = '0;
  logic        BUS_ACK = 1'b0;
  logic        BUSY;
  logic        ERR;

  int n_vec = 0;
  int n_err = 0;

  gpmc_bus_ctrl #(.ADDR_W(16), .SYNC_STAGES(2), .ACK_TIMEOUT(10), .ERR_DATA(16'hDEAD)) dut (
    .CLK_100M(CLK_100M), .RST(RST),
    .GPMC_AD_IN(GPMC_AD_IN), .GPMC_AD_OUT(GPMC_AD_OUT), .GPMC_AD_OE(GPMC_AD_OE),
    .GPMC_ADVN(GPMC_ADVN), .GPMC_CSN1(GPMC_CSN1), .GPMC_WEIN(GPMC_WEIN),
    .GPMC_OEN(GPMC_OEN), .GPMC_BE0N(GPMC_BE0N),
    .BUS_ADDR(BUS_ADDR), .BUS_WDATA(BUS_WDATA), .BUS_BE(BUS_BE),
    .BUS_WE(BUS_WE), .BUS_RE(BUS_RE), .BUS_RDATA(BUS_RDATA), .BUS_ACK(BUS_ACK),
    .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK_100M = ~CLK_100M;

  typedef struct {
    bit          rd;
    logic [15:0] addr;
    bit          be0n;
    logic [15:0] dat;
    int          dly;
    logic [1:0]  be;
  } vec_t;

  vec_t tbl [5];

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK_100M);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic addr_phase(input logic [15:0] a, input bit be0n);
    GPMC_CSN1 = 1'b0; GPMC_ADVN = 1'b0; GPMC_AD_IN = a; GPMC_BE0N = be0n;
    cyc(2);
    GPMC_ADVN = 1'b1;
    cyc(4);
  endtask

  // drop OEN and wait (bounded) for the read request pulse
  task automatic start_read(input logic [15:0] a, input bit be0n, output bit ok);
    addr_phase(a, be0n);
    GPMC_OEN = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      cyc(1);
      ok = BUS_RE;
    end
    chk("re_seen", {31'd0, ok}, 32'd1);
  endtask

  task automatic ack(input logic [15:0] d);
    BUS_ACK = 1'b1; BUS_RDATA = d;
    cyc(1);
    BUS_ACK = 1'b0;
  endtask

  task automatic end_access;
    GPMC_OEN = 1'b1; GPMC_WEIN = 1'b1; GPMC_CSN1 = 1'b1;
    cyc(5);
  endtask

  initial begin
    bit ok;
    int seen;

    tbl[0] = '{rd: 1'b0, addr: 16'h0012, be0n: 1'b0, dat: 16'hA5A5, dly: 1, be: 2'b11};
    tbl[1] = '{rd: 1'b1, addr: 16'h0034, be0n: 1'b0, dat: 16'h1234, dly: 3, be: 2'b11};
    tbl[2] = '{rd: 1'b0, addr: 16'h00FF, be0n: 1'b1, dat: 16'h5A5A, dly: 2, be: 2'b10};
    tbl[3] = '{rd: 1'b1, addr: 16'hBEEF, be0n: 1'b1, dat: 16'hCAFE, dly: 1, be: 2'b10};
    tbl[4] = '{rd: 1'b0, addr: 16'hFFFF, be0n: 1'b0, dat: 16'h0000, dly: 4, be: 2'b11};

    // reset state
    cyc(3);
    chk("rst_oe", {31'd0, GPMC_AD_OE}, 32'd0);
    chk("rst_adout", {16'd0, GPMC_AD_OUT}, 32'd0);
    chk("rst_addr", {16'd0, BUS_ADDR}, 32'd0);
    chk("rst_wdata", {16'd0, BUS_WDATA}, 32'd0);
    chk("rst_be", {30'd0, BUS_BE}, 32'd0);
    chk("rst_we_re", {30'd0, BUS_WE, BUS_RE}, 32'd0);
    chk("rst_busy_err", {30'd0, BUSY, ERR}, 32'd0);
    RST = 1'b0;
    cyc(3);

    // table of complete writes and reads
    for (int v = 0; v < 5; v++) begin
      if (!tbl[v].rd) begin
        addr_phase(tbl[v].addr, tbl[v].be0n);
        GPMC_AD_IN = tbl[v].dat;
        GPMC_WEIN = 1'b0;
        cyc(3);
        GPMC_WEIN = 1'b1;
        cyc(3);
        chk("wr_we_early", {31'd0, BUS_WE}, 32'd0);
        cyc(1);
        chk("wr_we_pulse", {31'd0, BUS_WE}, 32'd1);
        chk("wr_addr", {16'd0, BUS_ADDR}, {16'd0, tbl[v].addr});
        chk("wr_wdata", {16'd0, BUS_WDATA}, {16'd0, tbl[v].dat});
        chk("wr_be", {30'd0, BUS_BE}, {30'd0, tbl[v].be});
        cyc(1);
        chk("wr_we_single", {31'd0, BUS_WE}, 32'd0);
        if (tbl[v].dly > 1) cyc(tbl[v].dly - 1);
        ack(16'h0000);
        chk("wr_done_busy", {31'd0, BUSY}, 32'd1);
        GPMC_CSN1 = 1'b1;
        cyc(4);
        chk("wr_idle_busy", {31'd0, BUSY}, 32'd0);
      end else begin
        start_read(tbl[v].addr, tbl[v].be0n, ok);
        chk("rd_addr", {16'd0, BUS_ADDR}, {16'd0, tbl[v].addr});
        chk("rd_be", {30'd0, BUS_BE}, {30'd0, tbl[v].be});
        cyc(1);
        chk("rd_re_single", {31'd0, BUS_RE}, 32'd0);
        if (tbl[v].dly > 1) cyc(tbl[v].dly - 1);
        chk("rd_oe_before_ack", {31'd0, GPMC_AD_OE}, 32'd0);
        ack(tbl[v].dat);
        chk("rd_oe", {31'd0, GPMC_AD_OE}, 32'd1);
        chk("rd_data", {16'd0, GPMC_AD_OUT}, {16'd0, tbl[v].dat});
        cyc(2);
        chk("rd_oe_hold", {31'd0, GPMC_AD_OE}, 32'd1);
        GPMC_OEN = 1'b1;
        cyc(1);
        chk("rd_oe_sync", {31'd0, GPMC_AD_OE}, 32'd1);
        cyc(1);
        chk("rd_oe_drop", {31'd0, GPMC_AD_OE}, 32'd0);
        chk("rd_done_busy", {31'd0, BUSY}, 32'd1);
        GPMC_CSN1 = 1'b1;
        cyc(4);
        chk("rd_idle_busy", {31'd0, BUSY}, 32'd0);
      end
      chk("no_err", {31'd0, ERR}, 32'd0);
    end

    // CS abort in WAIT_ACK, stale ack must be discarded by the next access
    start_read(16'h0040, 1'b0, ok);
    cyc(1);
    GPMC_CSN1 = 1'b1; GPMC_OEN = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      if (GPMC_AD_OE) seen++;
    end
    chk("abort_no_oe", seen, 0);
    chk("abort_idle", {31'd0, BUSY}, 32'd0);
    start_read(16'h0050, 1'b0, ok);
    cyc(1);
    ack(16'hBAD0);
    chk("stale_ack_no_oe", {31'd0, GPMC_AD_OE}, 32'd0);
    chk("stale_ack_busy", {31'd0, BUSY}, 32'd1);
    cyc(1);
    ack(16'h7777);
    chk("after_abort_oe", {31'd0, GPMC_AD_OE}, 32'd1);
    chk("after_abort_data", {16'd0, GPMC_AD_OUT}, 32'h7777);
    end_access();

    // ack timeout (or, without the option, an indefinite wait)
    start_read(16'h0060, 1'b0, ok);
`ifdef GPMC_ACK_TIMEOUT_EN
    cyc(10);
    chk("tmo_err_early", {31'd0, ERR}, 32'd0);
    cyc(1);
    chk("tmo_err", {31'd0, ERR}, 32'd1);
    chk("tmo_oe", {31'd0, GPMC_AD_OE}, 32'd1);
    chk("tmo_data", {16'd0, GPMC_AD_OUT}, 32'hDEAD);
`else
    cyc(40);
    chk("wait_busy", {31'd0, BUSY}, 32'd1);
    chk("wait_no_err", {31'd0, ERR}, 32'd0);
    chk("wait_no_oe", {31'd0, GPMC_AD_OE}, 32'd0);
    ack(16'h4242);
    chk("late_ack_data", {16'd0, GPMC_AD_OUT}, 32'h4242);
`endif
    end_access();

    // WEIN and OEN low together: protocol error, no request
    addr_phase(16'h0077, 1'b0);
    GPMC_WEIN = 1'b0; GPMC_OEN = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (BUS_WE || BUS_RE) seen++;
    end
    chk("perr_no_req", seen, 0);
    chk("perr_err", {31'd0, ERR}, 32'd1);
    chk("perr_busy", {31'd0, BUSY}, 32'd1);
    end_access();
    chk("perr_idle", {31'd0, BUSY}, 32'd0);
    chk("perr_sticky", {31'd0, ERR}, 32'd1);

    // reset while driving read data
    start_read(16'h0088, 1'b0, ok);
    cyc(1);
    ack(16'h9999);
    chk("pre_rst_oe", {31'd0, GPMC_AD_OE}, 32'd1);
    RST = 1'b1;
    cyc(1);
    chk("rst_mid_oe", {31'd0, GPMC_AD_OE}, 32'd0);
    chk("rst_mid_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_mid_err", {31'd0, ERR}, 32'd0);
    chk("rst_mid_adout", {16'd0, GPMC_AD_OUT}, 32'd0);
    RST = 1'b0;
    end_access();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gpmc_bus_ctrl.md
Name: gpmc_bus_ctrl

Overview:
- Sequences asynchronous multiplexed GPMC accesses from the BeagleBone (CS1 region, 16-bit AD bus) into single-cycle requests on the internal FPGA register bus, all in the CLK_100M domain.
- Sits between the GPMC pins and the register/peripheral decode logic.
- Owns the AD bus direction and handles read/write sequencing, the ack handshake and the ack timeout.

Parameters:
- ADDR_W, 16, internal register-bus address width; the latched AD value is zero-extended or truncated to this width.
- SYNC_STAGES, 2, synchronizer depth for GPMC strobes; legal range 2..4.
- ACK_TIMEOUT, 255, cycles to wait for BUS_ACK before aborting; legal range 1..65535.
- ERR_DATA, 16'hDEAD, read data returned when an access times out.

Ports:
- CLK_100M  in  1  system clock, 100 MHz.
- RST  in  1  reset, synchronous, active-high.
- GPMC_AD_IN  in  16  AD pins, input path.
- GPMC_AD_OUT  out  16  AD pins, output path.
- GPMC_AD_OE  out  1  drive enable for AD pins; 1 = FPGA drives.
- GPMC_ADVN  in  1  address valid, active-low.
- GPMC_CSN1  in  1  chip select, active-low.
- GPMC_WEIN  in  1  write enable, active-low.
- GPMC_OEN  in  1  output enable, active-low.
- GPMC_BE0N  in  1  low-byte enable, active-low.
- BUS_ADDR  out  ADDR_W  register-bus address.
- BUS_WDATA  out  16  write data.
- BUS_BE  out  2  byte enables, active-high.
- BUS_WE  out  1  write request pulse.
- BUS_RE  out  1  read request pulse.
- BUS_RDATA  in  16  read data, valid with BUS_ACK.
- BUS_ACK  in  1  one-cycle completion from the slave.
- BUSY  out  1  high while not IDLE; drives a LED.
- ERR  out  1  sticky timeout flag; cleared only by RST.

Behaviour:
- Reset values: all outputs 0, state IDLE, all synchronizer flops at the inactive level (1).
- Synchronization:
  - ADVN, CSN1, WEIN and OEN pass through SYNC_STAGES flops.
  - GPMC_AD_IN is registered once; sampling uses the registered AD value that is aligned with the synchronized strobe.
  - Edges are detected on the final synchronizer stage.
- States: IDLE, ADDR, WR_REQ, RD_REQ, WAIT_ACK, DRIVE, DONE.
- IDLE -> ADDR: synchronized CSN1 low and ADVN low.
- ADDR:
  - On the ADVN rising edge, latch AD into BUS_ADDR.
  - BUS_BE = {1'b1, ~GPMC_BE0N}.
  - Then wait for WEIN falling (write) or OEN falling (read).
- Write path:
  - On the WEIN rising edge, latch AD into BUS_WDATA and go to WR_REQ.
  - WR_REQ: BUS_WE = 1 for exactly one cycle, then WAIT_ACK.
- Read path:
  - On the OEN falling edge go to RD_REQ.
  - RD_REQ: BUS_RE = 1 for exactly one cycle, then WAIT_ACK.
- WAIT_ACK:
  - On BUS_ACK: for reads, capture BUS_RDATA into GPMC_AD_OUT and go to DRIVE; for writes, go to DONE.
  - BUS_ACK arriving in the same cycle as the request pulse is not accepted; only acks after the request cycle count.
- DRIVE: GPMC_AD_OE = 1 while synchronized OEN is low. When OEN goes high, AD_OE drops to 0 that same cycle, then DONE.
- DONE: wait for CSN1 high, then IDLE.
- Latency:
  - Write: BUS_WE asserts SYNC_STAGES+2 cycles after the WEIN rising edge at the pin.
  - Read: data is on the pins 1 cycle after BUS_ACK.
- GPMC_AD_OE is never 1 outside DRIVE, and never 1 while OEN is high or CSN1 is high.
- CSN1 rising in any state other than IDLE or DONE aborts the access:
  - AD_OE drops to 0 and no further request pulse is issued.
  - A request already issued remains outstanding; the following ack is discarded.
  - Return to IDLE.
- WEIN and OEN both low at the same time: treat as a protocol error, set ERR, go to DONE with no bus request.
- RST mid-access: immediate return to IDLE, outputs cleared, ERR cleared.
- BUSY = (state != IDLE).

Optional Feature:
- Macro: GPMC_ACK_TIMEOUT_EN.
- Defined:
  - A 16-bit counter runs in WAIT_ACK.
  - When it reaches ACK_TIMEOUT without an ack: set ERR; for reads load ERR_DATA and go to DRIVE; for writes go to DONE.
  - The counter clears on entering WAIT_ACK.
- Undefined: WAIT_ACK waits indefinitely; the ERR timeout source is absent (the protocol-error source remains).

Test Plan:
- Write: ADVN pulse with AD=16'h0012, then WEIN low/high with AD=16'hA5A5 -> one BUS_WE pulse, BUS_ADDR=0x0012, BUS_WDATA=0xA5A5, BUS_BE=2'b11.
- Read: addr 0x0034, OEN low, slave acks 3 cycles after BUS_RE with 0x1234 -> AD_OE=1, AD_OUT=0x1234 until OEN high, then AD_OE=0 the same cycle.
- BE0N=1 during address phase -> BUS_BE=2'b10.
- CSN1 rises while in WAIT_ACK -> no AD_OE, return to IDLE, later ack ignored, next access completes normally.
- With GPMC_ACK_TIMEOUT_EN, ACK_TIMEOUT=10, no ack -> after 10 cycles ERR=1 and the read returns 0xDEAD.
- RST asserted during DRIVE -> next cycle AD_OE=0, BUSY=0, ERR=0.
